mem_bus_splitter: RTL and testbench
===================================

# mem_bus_splitter

Parametrised native-memory-bus splitter between the picorv32 core's native memory port (`mem_valid`/`mem_ready` handshake) and up to NUM_SLAVES memory-mapped targets. It decodes one address field to pick a slave and registers the request and the response. Transactions to unmapped regions, and slaves that never answer, complete with an error response so the core cannot hang. It sits in the SoC top level between the core and the RAM/ROM/peripheral blocks.

## Interface

Parameters:
- NUM_SLAVES, 4: number of slave channels, 1..16.
- SEL_MSB, 31: upper bit of the region-select field in the address.
- SEL_LSB, 28: lower bit of the region-select field; region index = mem_addr[SEL_MSB:SEL_LSB].
- TIMEOUT, 255: ACCESS cycles allowed before the splitter forces an error response; 0 disables the timeout; legal range 0..65535.
- ERR_RDATA, 32'hDEADBEEF: read data returned on an error response.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- resetn  in  1  reset, synchronous and active-low.
- mem_valid  in  1  request from the core.
- mem_instr  in  1  request is an instruction fetch.
- mem_ready  out  1  one-cycle completion pulse to the core.
- mem_addr  in  32  request address.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte write strobes; 0 means a read.
- mem_rdata  out  32  read data, valid while mem_ready=1.
- s_valid  out  NUM_SLAVES  one-hot request to the selected slave.
- s_ready  in  NUM_SLAVES  per-slave completion.
- s_addr  out  32  registered request address, shared by all slaves.
- s_wdata  out  32  registered write data, shared.
- s_wstrb  out  4  registered strobes, shared.
- s_instr  out  1  registered instruction-fetch flag, shared.
- s_rdata  in  32*NUM_SLAVES  slave read data; slave k uses bits [32k+31:32k].
- bus_error  out  1  one-cycle pulse, coincident with mem_ready, for an error response.
- err_addr  out  32  address of the most recent error response.
- err_count  out  16  count of error responses, saturating at 16'hFFFF.

## Operation

- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE, mem_valid=1:
  - Latch addr/wdata/wstrb/instr into the s_* registers.
  - Latch sel = mem_addr[SEL_MSB:SEL_LSB].
  - sel < NUM_SLAVES: go to ACCESS and clear the timeout counter.
  - sel >= NUM_SLAVES (unmapped): go to RESP with err=1 and rdata=ERR_RDATA.
- ACCESS:
  - s_valid[sel]=1; all other s_valid bits are 0.
  - s_ready[sel]=1: capture the s_rdata slice for sel into the rdata register, set err=0, go to RESP.
  - s_ready bits of unselected slaves are ignored.
  - Otherwise increment the counter. When TIMEOUT!=0 and the counter reaches TIMEOUT: err=1, rdata=ERR_RDATA, go to RESP.
  - s_ready in the same cycle as the timeout: s_ready wins and the response is normal.
- RESP:
  - mem_ready=1 and mem_rdata=rdata register.
  - bus_error=err.
  - If err: err_addr<=s_addr and err_count increments, saturating.
  - Always go to IDLE next cycle.
- mem_rdata is driven only in RESP; it is 0 in other states.
- On writes, rdata holds whatever the slave drove, and the core ignores it.
- The splitter does not abort a transaction on mem_valid deassertion. A transaction always completes with a RESP pulse.
- s_addr/s_wdata/s_wstrb/s_instr are stable from ACCESS entry until the next IDLE capture.

## Timing

- Reset (resetn=0 at an edge): state=IDLE; s_valid=0, mem_ready=0, bus_error=0, mem_rdata=0; s_addr/s_wdata/err_addr=0, s_wstrb=0, s_instr=0, err_count=0.
- Reset mid-ACCESS drops s_valid at that same edge, and no mem_ready is produced.
- Mapped access, request seen in IDLE at cycle 0:
  - s_valid=1 from cycle 1.
  - s_ready sampled in cycle n≥1.
  - mem_ready=1 in cycle n+1.
  - Minimum latency is 2 cycles from mem_valid to mem_ready.
- Unmapped access: mem_ready=1 and bus_error=1 in cycle 1.
- Timeout: the error RESP occurs in cycle TIMEOUT+1. s_valid is high for exactly TIMEOUT cycles (cycles 1..TIMEOUT).
- Back-to-back: a new request is accepted in the IDLE cycle directly after RESP. Sustained throughput is one transaction per 3 cycles.
- Never more than one s_valid bit high; never mem_ready high for two consecutive cycles.

## Test plan

- Read slave 1 at 0x1000_0004; slave answers s_ready=1 with s_rdata slice = 0x12345678 on the first ACCESS cycle -> mem_ready=1 at cycle 2, mem_rdata=0x12345678, s_valid=4'b0010 only in cycle 1, bus_error=0.
- Write to slave 3 at 0x3000_0010, wdata=0xA5A5A5A5, wstrb=4'b0011, s_ready delayed 5 cycles -> s_addr/s_wdata/s_wstrb stable throughout, mem_ready at cycle 6.
- Access 0x5000_0000 with NUM_SLAVES=4 -> mem_ready and bus_error at cycle 1, mem_rdata=0xDEADBEEF, err_addr=0x5000_0000, err_count=1, no s_valid asserted.
- TIMEOUT=8, slave 0 never ready -> s_valid[0] high for cycles 1..8, error RESP at cycle 9; repeat with s_ready arriving exactly at cycle 8 -> normal response, err_count unchanged.
- resetn=0 during the 3rd ACCESS cycle -> s_valid=0 at the next edge, state IDLE, no mem_ready, a following request completes normally.
- 100 random back-to-back requests across mapped and unmapped regions -> one mem_ready per request, s_valid always one-hot, err_count equals the number of unmapped requests plus timed-out requests.

Source files
------------

// File: rtl/mem_bus_splitter.sv
// Native memory bus splitter: decodes one address field to pick a slave, registers
// request and response, and turns unmapped or unanswered accesses into error responses.
//
// state  | meaning
// IDLE   | waiting for mem_valid; captures the request when it arrives
// ACCESS | s_valid held on the selected slave until s_ready or timeout
// RESP   | one-cycle mem_ready pulse to the core, error bookkeeping
module mem_bus_splitter #(
  parameter int          NUM_SLAVES = 4,
  parameter int          SEL_MSB    = 31,
  parameter int          SEL_LSB    = 28,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] ERR_RDATA  = 32'hDEADBEEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     mem_valid,
  input  logic                     mem_instr,
  output logic                     mem_ready,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [3:0]               mem_wstrb,
  output logic [31:0]              mem_rdata,
  output logic [NUM_SLAVES-1:0]    s_valid,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wstrb,
  output logic                     s_instr,
  input  logic [32*NUM_SLAVES-1:0] s_rdata,
  output logic                     bus_error,
  output logic [31:0]              err_addr,
  output logic [15:0]              err_count
);

  localparam int SEL_W = SEL_MSB - SEL_LSB + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [SEL_W-1:0]  sel_q;
  logic [15:0]       tmo_cnt;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [SEL_W-1:0]      req_sel;
  logic                  req_mapped;
  logic [NUM_SLAVES-1:0] sel_onehot;
  logic                  sel_ready;
  logic [31:0]           sel_rdata;
  logic                  timeout_hit;

  assign req_sel    = mem_addr[SEL_MSB:SEL_LSB];
  assign req_mapped = (32'(req_sel) < 32'(NUM_SLAVES));

  // Only the latched selection's ready and data are looked at; others are ignored.
  always_comb begin
    sel_onehot = '0;
    sel_ready  = 1'b0;
    sel_rdata  = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (sel_q == SEL_W'(k)) begin
        sel_onehot[k] = 1'b1;
        sel_ready     = s_ready[k];
        sel_rdata     = s_rdata[32*k +: 32];
      end
    end
  end

  // Fires in ACCESS cycle number TIMEOUT, so s_valid is up for exactly TIMEOUT cycles.
  assign timeout_hit = (TIMEOUT != 0) && (({1'b0, tmo_cnt} + 17'd1) == 17'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mem_valid) state_next = req_mapped ? ACCESS : RESP;
      ACCESS:  if (sel_ready || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_valid   = (state == ACCESS) ? sel_onehot : '0;
    mem_ready = (state == RESP);
    mem_rdata = (state == RESP) ? rdata_q : 32'h0;
    bus_error = (state == RESP) && err_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      s_instr   <= 1'b0;
      sel_q     <= '0;
      tmo_cnt   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_valid) begin
            s_addr  <= mem_addr;
            s_wdata <= mem_wdata;
            s_wstrb <= mem_wstrb;
            s_instr <= mem_instr;
            sel_q   <= req_sel;
            tmo_cnt <= '0;
            err_q   <= !req_mapped;
            if (!req_mapped) rdata_q <= ERR_RDATA;
          end
        end
        ACCESS: begin
          // A ready arriving in the timeout cycle still completes normally.
          if (sel_ready) begin
            rdata_q <= sel_rdata;
            err_q   <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
            if (timeout_hit) begin
              rdata_q <= ERR_RDATA;
              err_q   <= 1'b1;
            end
          end
        end
        RESP: begin
          if (err_q) begin
            err_addr <= s_addr;
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_splitter.sv
// Bench for mem_bus_splitter: directed scenarios plus randomized back-to-back traffic
// checked against a per-transaction latency/response model.
module tb_mem_bus_splitter;

  localparam int          NS   = 4;
  localparam int          TO   = 8;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic             clk = 1'b0;
  logic             resetn;
  logic             mem_valid, mem_instr, mem_ready;
  logic [31:0]      mem_addr, mem_wdata, mem_rdata;
  logic [3:0]       mem_wstrb;
  logic [NS-1:0]    s_valid, s_ready;
  logic [31:0]      s_addr, s_wdata;
  logic [3:0]       s_wstrb;
  logic             s_instr;
  logic [32*NS-1:0] s_rdata;
  logic             bus_error;
  logic [31:0]      err_addr;
  logic [15:0]      err_count;

  int total = 0;
  int bad   = 0;
  int          exp_cnt   = 0;
  logic [31:0] exp_eaddr = '0;

  mem_bus_splitter #(.NUM_SLAVES(NS), .SEL_MSB(31), .SEL_LSB(28), .TIMEOUT(TO), .ERR_RDATA(ERRD)) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_instr(s_instr), .s_rdata(s_rdata),
    .bus_error(bus_error), .err_addr(err_addr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: response cycle and error flag from the address region and slave delay.
  function automatic int model_lat(input int sel, input int rdy);
    if (sel >= NS) return 1;
    if (rdy >= 1 && (TO == 0 || rdy <= TO)) return rdy + 1;
    return TO + 1;
  endfunction

  function automatic logic model_err(input int sel, input int rdy);
    if (sel >= NS) return 1'b1;
    return !(rdy >= 1 && (TO == 0 || rdy <= TO));
  endfunction

  // Plays the core and the addressed slave for one transaction and reports observations.
  // rdy_cyc = cycle (relative to request cycle 0) in which the slave raises s_ready; 0 = never.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic instr, input int rdy_cyc, input logic [31:0] sdata,
                         output int lat, output logic [31:0] rd, output logic be,
                         output int vld_cyc, output int proto_bad, output int stab_bad,
                         output logic pre_rdy);
    int            sel;
    logic [NS-1:0] oh;
    logic [NS-1:0] exp_v;
    sel = int'(addr[31:28]);
    oh  = '0;
    if (sel < NS) oh[sel] = 1'b1;
    if (mem_ready) step();
    pre_rdy = mem_ready;
    lat = -1; rd = '0; be = 1'b0; vld_cyc = 0; proto_bad = 0; stab_bad = 0;
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb; mem_instr = instr;
    for (int c = 0; c < 40; c++) begin
      for (int k = 0; k < NS; k++) begin
        s_rdata[32*k +: 32] = $urandom;
        s_ready[k] = (k == sel) ? 1'b0 : 1'($urandom_range(0, 1));
      end
      if (sel < NS && rdy_cyc >= 1 && c == rdy_cyc) begin
        s_ready[sel] = 1'b1;
        s_rdata[32*sel +: 32] = sdata;
      end
      step();
      exp_v = (sel < NS && !mem_ready) ? oh : '0;
      if (s_valid !== exp_v) proto_bad++;
      if (s_valid != '0) vld_cyc++;
      if (s_addr !== addr || s_wdata !== wdata || s_wstrb !== wstrb || s_instr !== instr) stab_bad++;
      if (mem_ready) begin
        lat = c + 1; rd = mem_rdata; be = bus_error;
        break;
      end else if (bus_error !== 1'b0 || mem_rdata !== 32'h0) begin
        proto_bad++;
      end
    end
    mem_valid = 1'b0;
    s_ready   = '0;
  endtask

  task automatic test_reset();
    int lat, vc, pb, sb; logic [31:0] rd; logic be, pr;
    resetn = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0;
    mem_wstrb = '0; s_ready = '0; s_rdata = '0;
    step(); step();
    resetn = 1'b1;
    step();
    run_txn(32'h7000_00AC, 32'h1122_3344, 4'hF, 1'b1, 0, 32'h0, lat, rd, be, vc, pb, sb, pr);
    step();
    total++; if (err_count !== 16'd1) begin bad++; $display("FAIL pre_reset_err_count got=%0d exp=1", err_count); end
    resetn = 1'b0;
    step();
    total++; if (mem_ready !== 1'b0 || bus_error !== 1'b0 || s_valid !== '0 || mem_rdata !== '0) begin
      bad++; $display("FAIL reset_outputs got rdy=%b err=%b sv=%b rdata=%h exp all 0", mem_ready, bus_error, s_valid, mem_rdata);
    end
    total++; if (s_addr !== '0 || s_wdata !== '0 || s_wstrb !== '0 || s_instr !== 1'b0) begin
      bad++; $display("FAIL reset_sregs got addr=%h wdata=%h wstrb=%h instr=%b exp 0", s_addr, s_wdata, s_wstrb, s_instr);
    end
    total++; if (err_addr !== '0 || err_count !== '0) begin
      bad++; $display("FAIL reset_err got addr=%h count=%0d exp 0", err_addr, err_count);
    end
    resetn = 1'b1;
    exp_cnt = 0; exp_eaddr = '0;
    step();
  endtask

  task automatic test_read();
    int lat, vc, pb, sb; logic [31:0] rd; logic be, pr;
    run_txn(32'h1000_0004, 32'h0, 4'h0, 1'b0, 1, 32'h1234_5678, lat, rd, be, vc, pb, sb, pr);
    total++; if (lat != 2) begin bad++; $display("FAIL read_latency got=%0d exp=2", lat); end
    total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL read_rdata got=%h exp=12345678", rd); end
    total++; if (be !== 1'b0) begin bad++; $display("FAIL read_bus_error got=%b exp=0", be); end
    total++; if (vc != 1 || pb != 0 || sb != 0 || pr !== 1'b0) begin
      bad++; $display("FAIL read_protocol got vcyc=%0d pbad=%0d sbad=%0d pre=%b exp 1/0/0/0", vc, pb, sb, pr);
    end
    step();
  endtask

  task automatic test_write_delay();
    int lat, vc, pb, sb; logic [31:0] rd; logic be, pr;
    run_txn(32'h3000_0010, 32'hA5A5_A5A5, 4'b0011, 1'b0, 5, 32'h0BAD_F00D, lat, rd, be, vc, pb, sb, pr);
    total++; if (lat != 6) begin bad++; $display("FAIL write_latency got=%0d exp=6", lat); end
    total++; if (sb != 0) begin bad++; $display("FAIL write_stable got=%0d unstable cycles exp=0", sb); end
    total++; if (vc != 5 || pb != 0 || be !== 1'b0) begin
      bad++; $display("FAIL write_protocol got vcyc=%0d pbad=%0d err=%b exp 5/0/0", vc, pb, be);
    end
    total++; if (rd !== 32'h0BAD_F00D) begin bad++; $display("FAIL write_rdata got=%h exp=0badf00d", rd); end
    step();
  endtask

  task automatic test_unmapped();
    int lat, vc, pb, sb; logic [31:0] rd; logic be, pr;
    run_txn(32'h5000_0000, 32'h0, 4'h0, 1'b0, 1, 32'h0, lat, rd, be, vc, pb, sb, pr);
    exp_cnt++; exp_eaddr = 32'h5000_0000;
    total++; if (lat != 1 || be !== 1'b1) begin bad++; $display("FAIL unmapped_resp got lat=%0d err=%b exp 1/1", lat, be); end
    total++; if (rd !== ERRD) begin bad++; $display("FAIL unmapped_rdata got=%h exp=%h", rd, ERRD); end
    total++; if (vc != 0 || pb != 0) begin bad++; $display("FAIL unmapped_svalid got vcyc=%0d pbad=%0d exp 0/0", vc, pb); end
    step();
    total++; if (err_addr !== exp_eaddr || err_count !== 16'(exp_cnt)) begin
      bad++; $display("FAIL unmapped_errlog got addr=%h cnt=%0d exp addr=%h cnt=%0d", err_addr, err_count, exp_eaddr, exp_cnt);
    end
  endtask

  task automatic test_timeout();
    int lat, vc, pb, sb; logic [31:0] rd; logic be, pr;
    run_txn(32'h0000_0100, 32'h0, 4'h0, 1'b1, 0, 32'h0, lat, rd, be, vc, pb, sb, pr);
    exp_cnt++; exp_eaddr = 32'h0000_0100;
    total++; if (lat != TO + 1 || be !== 1'b1 || rd !== ERRD) begin
      bad++; $display("FAIL timeout_resp got lat=%0d err=%b rdata=%h exp %0d/1/%h", lat, be, rd, TO + 1, ERRD);
    end
    total++; if (vc != TO || pb != 0) begin bad++; $display("FAIL timeout_svalid got vcyc=%0d pbad=%0d exp %0d/0", vc, pb, TO); end
    step();
    total++; if (err_count !== 16'(exp_cnt) || err_addr !== exp_eaddr) begin
      bad++; $display("FAIL timeout_errlog got cnt=%0d addr=%h exp cnt=%0d addr=%h", err_count, err_addr, exp_cnt, exp_eaddr);
    end
    run_txn(32'h0000_0200, 32'h0, 4'h0, 1'b0, TO, 32'hCAFE_0008, lat, rd, be, vc, pb, sb, pr);
    total++; if (lat != TO + 1 || be !== 1'b0 || rd !== 32'hCAFE_0008) begin
      bad++; $display("FAIL edge_ready_resp got lat=%0d err=%b rdata=%h exp %0d/0/cafe0008", lat, be, rd, TO + 1);
    end
    step();
    total++; if (err_count !== 16'(exp_cnt)) begin bad++; $display("FAIL edge_ready_errcnt got=%0d exp=%0d", err_count, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    int lat, vc, pb, sb, extra; logic [31:0] rd; logic be, pr;
    mem_valid = 1'b1; mem_addr = 32'h2000_0040; mem_wdata = '0; mem_wstrb = '0; mem_instr = 1'b0; s_ready = '0;
    step(); step(); step();
    total++; if (s_valid !== 4'b0100) begin bad++; $display("FAIL midreset_pre got sv=%b exp=0100", s_valid); end
    resetn = 1'b0; mem_valid = 1'b0;
    step();
    total++; if (s_valid !== '0 || mem_ready !== 1'b0) begin
      bad++; $display("FAIL midreset_drop got sv=%b rdy=%b exp 0/0", s_valid, mem_ready);
    end
    resetn = 1'b1;
    exp_cnt = 0; exp_eaddr = '0;
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      s_ready = 4'b0100;
      step();
      if (mem_ready) extra++;
    end
    s_ready = '0;
    total++; if (extra != 0) begin bad++; $display("FAIL midreset_stray_ready got=%0d exp=0", extra); end
    run_txn(32'h2000_0044, 32'h0, 4'h0, 1'b0, 2, 32'h7777_2222, lat, rd, be, vc, pb, sb, pr);
    total++; if (lat != 3 || be !== 1'b0 || rd !== 32'h7777_2222 || pb != 0) begin
      bad++; $display("FAIL midreset_after got lat=%0d err=%b rdata=%h pbad=%0d exp 3/0/77772222/0", lat, be, rd, pb);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int lat, vc, pb, sb, sel, rdy, elat;
    logic [31:0] rd, addr, sdata, erd;
    logic be, pr, eerr;
    for (int n = 0; n < 100; n++) begin
      addr = $urandom;
      addr[31:28] = 4'($urandom_range(0, 7));
      sel   = int'(addr[31:28]);
      rdy   = $urandom_range(0, 10);
      sdata = $urandom;
      run_txn(addr, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), rdy, sdata,
              lat, rd, be, vc, pb, sb, pr);
      elat = model_lat(sel, rdy);
      eerr = model_err(sel, rdy);
      erd  = eerr ? ERRD : sdata;
      if (eerr) begin exp_cnt++; exp_eaddr = addr; end
      total++; if (lat != elat || be !== eerr) begin
        bad++; $display("FAIL b2b_resp n=%0d got lat=%0d err=%b exp lat=%0d err=%b", n, lat, be, elat, eerr);
      end
      total++; if (rd !== erd) begin bad++; $display("FAIL b2b_rdata n=%0d got=%h exp=%h", n, rd, erd); end
      total++; if (pb != 0 || sb != 0 || pr !== 1'b0 || vc != ((sel < NS) ? elat - 1 : 0)) begin
        bad++; $display("FAIL b2b_protocol n=%0d got pbad=%0d sbad=%0d pre=%b vcyc=%0d", n, pb, sb, pr, vc);
      end
    end
    step();
    total++; if (err_count !== 16'(exp_cnt)) begin bad++; $display("FAIL b2b_err_count got=%0d exp=%0d", err_count, exp_cnt); end
    total++; if (err_addr !== exp_eaddr) begin bad++; $display("FAIL b2b_err_addr got=%h exp=%h", err_addr, exp_eaddr); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_delay();
    test_unmapped();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
